// File: rtl/frv_masked_pkg.sv
// Shared definitions for the masked bitwise unit: op codes and share/random indexing helpers.
package frv_masked_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_ANDN = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_XNOR = 3'd4,
        OP_NOT  = 3'd5
    } masked_op_e;

    // Number of fresh random words needed per DOM-indep multiplication.
    function automatic int n_rand_words(input int d);
        return ((d + 1) * d) / 2;
    endfunction

    // Row-major upper-triangle index of pair (i,j), i<j, among n shares.
    function automatic int rand_idx(input int i, input int j, input int n);
        return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

    function automatic logic is_nonlinear(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_ANDN) || (op == OP_OR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return (op > OP_NOT);
    endfunction

endpackage

// File: rtl/frv_masked_bitwise_dom_mul.sv
// DOM-indep multiplier core: registered blinded cross terms, then a registered per-share compression.
module frv_dom_indep_mul
    import frv_masked_pkg::*;
#(
    parameter int  D         = 1,
    parameter int  BIT_WIDTH = 32,
    localparam int N         = D + 1,
    localparam int L         = n_rand_words(D)
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   i_en1,
    input  logic                   i_en2,
    input  logic                   i_neg,
    input  logic [N*BIT_WIDTH-1:0] i_a,
    input  logic [N*BIT_WIDTH-1:0] i_b,
    input  logic [L*BIT_WIDTH-1:0] i_rand,
    output logic [N*BIT_WIDTH-1:0] o_c
);
    localparam int W = BIT_WIDTH;

    logic [N*N*W-1:0] t_q;
    logic [N*N*W-1:0] t_d;
    logic [N*W-1:0]   c_q;
    logic [N*W-1:0]   c_d;
    logic [N*W-1:0]   c_sum_s;

    // Stage-1 products; each off-diagonal pair shares one random word so it cancels on recombination.
    always_comb begin
        t_d = t_q;
        if (i_en1) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i == j) begin
                        t_d[(i*N+j)*W +: W] = i_a[i*W +: W] & i_b[j*W +: W];
                    end else if (i < j) begin
                        t_d[(i*N+j)*W +: W] = (i_a[i*W +: W] & i_b[j*W +: W])
                                            ^ i_rand[rand_idx(i, j, N)*W +: W];
                    end else begin
                        t_d[(i*N+j)*W +: W] = (i_a[i*W +: W] & i_b[j*W +: W])
                                            ^ i_rand[rand_idx(j, i, N)*W +: W];
                    end
                end
            end
        end else begin
            t_d = t_q;
        end
    end

    // Compress each registered row into one output share, with optional share-0 negation.
    always_comb begin
        c_sum_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_sum_s[i*W +: W] = c_sum_s[i*W +: W] ^ t_q[(i*N+j)*W +: W];
            end
        end
        if (i_neg) begin
            c_sum_s[W-1:0] = ~c_sum_s[W-1:0];
        end else begin
            c_sum_s[W-1:0] = c_sum_s[W-1:0];
        end
    end

    // Stage-2 load only when a non-linear op advances, so idle cycles do not toggle the register.
    always_comb begin
        if (i_en2) begin
            c_d = c_sum_s;
        end else begin
            c_d = c_q;
        end
    end

    // Stage-1 and stage-2 data registers with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            t_q <= '0;
            c_q <= '0;
        end else begin
            t_q <= t_d;
            c_q <= c_d;
        end
    end

    assign o_c = c_q;

endmodule

// File: rtl/frv_masked_bitwise_dom.sv
// Masked bitwise unit: every op passes two register stages with fresh randomness mixed in at stage 1.
module frv_masked_bitwise_dom
    import frv_masked_pkg::*;
#(
    parameter int  D         = 1,
    parameter int  BIT_WIDTH = 32,
    localparam int N         = D + 1,
    localparam int L         = n_rand_words(D)
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   i_valid,
    input  logic                   i_flush,
    input  logic [2:0]             i_op,
    input  logic [N*BIT_WIDTH-1:0] i_a,
    input  logic [N*BIT_WIDTH-1:0] i_b,
    input  logic [L*BIT_WIDTH-1:0] i_rand,
    output logic                   o_valid,
    output logic                   o_err,
    output logic [N*BIT_WIDTH-1:0] o_res,
    output logic                   o_busy
);
    localparam int W = BIT_WIDTH;

    logic           acc_s;
    logic           en2_s;
    logic           s1_nl_s;
    logic [N*W-1:0] a_pre_s;
    logic [N*W-1:0] b_pre_s;
    logic [N*W-1:0] x_s;
    logic [N*W-1:0] lin_s;
    logic [W-1:0]   rsum_s;
    logic [N*W-1:0] mul_c_s;

    logic           s1_valid_q, s1_valid_d;
    logic [2:0]     s1_op_q,    s1_op_d;
    logic           s1_err_q,   s1_err_d;
    logic [N*W-1:0] s1_lin_q,   s1_lin_d;
    logic           s2_valid_q, s2_valid_d;
    logic           s2_err_q,   s2_err_d;
    logic           s2_nl_q,    s2_nl_d;
    logic [N*W-1:0] s2_lin_q,   s2_lin_d;

    // Share-0 pre-negation: OR is built as ~(~a & ~b), ANDN as a & ~b.
    always_comb begin
        a_pre_s = i_a;
        b_pre_s = i_b;
        case (i_op)
            OP_OR: begin
                a_pre_s[W-1:0] = ~i_a[W-1:0];
                b_pre_s[W-1:0] = ~i_b[W-1:0];
            end
            OP_ANDN: begin
                b_pre_s[W-1:0] = ~i_b[W-1:0];
            end
            default: begin
                a_pre_s = i_a;
                b_pre_s = i_b;
            end
        endcase
    end

    // Linear refresh: blind shares 0..N-2 and fold the same words into the last share.
    always_comb begin
        if (i_op == OP_NOT) begin
            x_s = i_a;
        end else begin
            x_s = i_a ^ i_b;
        end
        rsum_s = '0;
        lin_s  = x_s;
        for (int k = 0; k < N - 1; k++) begin
            lin_s[k*W +: W] = x_s[k*W +: W] ^ i_rand[k*W +: W];
            rsum_s          = rsum_s ^ i_rand[k*W +: W];
        end
        lin_s[(N-1)*W +: W] = x_s[(N-1)*W +: W] ^ rsum_s;
    end

    // Stage-1 next state: a flush drops any request presented in the same cycle.
    always_comb begin
        acc_s      = i_valid & ~i_flush;
        s1_valid_d = acc_s;
        if (acc_s) begin
            s1_op_d  = i_op;
            s1_err_d = is_reserved(i_op);
        end else begin
            s1_op_d  = s1_op_q;
            s1_err_d = s1_err_q;
        end
        if (acc_s && !is_nonlinear(i_op) && !is_reserved(i_op)) begin
            s1_lin_d = lin_s;
        end else begin
            s1_lin_d = s1_lin_q;
        end
    end

    // Stage-2 next state: output negation for XNOR/NOT and zero shares for reserved codes.
    always_comb begin
        en2_s      = s1_valid_q & ~i_flush;
        s1_nl_s    = is_nonlinear(s1_op_q);
        s2_valid_d = en2_s;
        s2_err_d   = en2_s & s1_err_q;
        s2_nl_d    = s2_nl_q;
        s2_lin_d   = s2_lin_q;
        if (en2_s) begin
            s2_nl_d = s1_nl_s;
            if (s1_err_q) begin
                s2_lin_d = '0;
            end else if (!s1_nl_s) begin
                s2_lin_d = s1_lin_q;
                if ((s1_op_q == OP_XNOR) || (s1_op_q == OP_NOT)) begin
                    s2_lin_d[W-1:0] = ~s1_lin_q[W-1:0];
                end else begin
                    s2_lin_d[W-1:0] = s1_lin_q[W-1:0];
                end
            end else begin
                s2_lin_d = s2_lin_q;
            end
        end else begin
            s2_nl_d  = s2_nl_q;
            s2_lin_d = s2_lin_q;
        end
    end

    // Pipeline control and linear data registers; reset dominates flush.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'd0;
            s1_err_q   <= 1'b0;
            s1_lin_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_nl_q    <= 1'b0;
            s2_lin_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_err_q   <= s1_err_d;
            s1_lin_q   <= s1_lin_d;
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_nl_q    <= s2_nl_d;
            s2_lin_q   <= s2_lin_d;
        end
    end

    frv_dom_indep_mul #(
        .D         (D),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_mul (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .i_en1    (acc_s & is_nonlinear(i_op)),
        .i_en2    (en2_s & s1_nl_s),
        .i_neg    (s1_op_q == OP_OR),
        .i_a      (a_pre_s),
        .i_b      (b_pre_s),
        .i_rand   (i_rand),
        .o_c      (mul_c_s)
    );

    // Per-share selection between two registered results; shares are never mixed here.
    assign o_res   = s2_nl_q ? mul_c_s : s2_lin_q;
    assign o_valid = s2_valid_q;
    assign o_err   = s2_err_q;
    assign o_busy  = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_frv_masked_bitwise_dom.sv
// Self-checking bench: directed D=1 scenarios plus a randomized D=2 run against an unmasked reference.
module tb_frv_masked_bitwise_dom;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        v1, f1, ov1, oe1, ob1;
    logic [2:0]  op1;
    logic [15:0] a1, b1, res1;
    logic [7:0]  r1;

    logic        v2, f2, ov2, oe2, ob2;
    logic [2:0]  op2;
    logic [23:0] a2, b2, r2, res2;

    int checks = 0;
    int errors = 0;

    frv_masked_bitwise_dom #(.D(1), .BIT_WIDTH(8)) dut1 (
        .g_clk(clk), .g_resetn(rst_n), .i_valid(v1), .i_flush(f1), .i_op(op1),
        .i_a(a1), .i_b(b1), .i_rand(r1),
        .o_valid(ov1), .o_err(oe1), .o_res(res1), .o_busy(ob1)
    );

    frv_masked_bitwise_dom #(.D(2), .BIT_WIDTH(8)) dut2 (
        .g_clk(clk), .g_resetn(rst_n), .i_valid(v2), .i_flush(f2), .i_op(op2),
        .i_a(a2), .i_b(b2), .i_rand(r2),
        .o_valid(ov2), .o_err(oe2), .o_res(res2), .o_busy(ob2)
    );

    // Unmasked meaning of each op code.
    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a & ~b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a ^ b);
            3'd5:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] um1(input logic [15:0] s);
        return s[7:0] ^ s[15:8];
    endfunction

    function automatic logic [7:0] um2(input logic [23:0] s);
        return s[7:0] ^ s[15:8] ^ s[23:16];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 1'b1; f1 = 1'b0; op1 = 3'd0; a1 = 16'hAA5A; b1 = 16'h2D11; r1 = 8'hFF;
        v2 = 1'b1; f2 = 1'b0; op2 = 3'd0; a2 = 24'h123456; b2 = 24'h654321; r2 = 24'hFFFFFF;
        step();
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1: got %b expected 0", ov1); end
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL reset_oe1: got %b expected 0", oe1); end
        checks++; if (ob1 !== 1'b0) begin errors++; $display("FAIL reset_ob1: got %b expected 0", ob1); end
        checks++; if (res1 !== 16'h0000) begin errors++; $display("FAIL reset_res1: got %h expected 0000", res1); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2: got %b expected 0", ov2); end
        checks++; if (res2 !== 24'h000000) begin errors++; $display("FAIL reset_res2: got %h expected 000000", res2); end
        v1 = 1'b0; v2 = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (ob1 !== 1'b0) begin errors++; $display("FAIL reset_idle_ob1: got %b expected 0", ob1); end
        checks++; if (ob2 !== 1'b0) begin errors++; $display("FAIL reset_idle_ob2: got %b expected 0", ob2); end
    endtask

    task automatic test_and();
        op1 = 3'd0; a1 = 16'hAA5A; b1 = 16'h2D11; r1 = 8'hFF; v1 = 1'b1;
        step();
        v1 = 1'b0;
        checks++; if (ob1 !== 1'b1) begin errors++; $display("FAIL and_busy: got %b expected 1", ob1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL and_early_valid: got %b expected 0", ov1); end
        step();
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL and_valid: got %b expected 1", ov1); end
        checks++; if (um1(res1) !== 8'h30) begin errors++; $display("FAIL and_result: got %h expected 30", um1(res1)); end
        checks++; if (oe1 !== 1'b0) begin errors++; $display("FAIL and_err: got %b expected 0", oe1); end
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL and_pulse: got %b expected 0", ov1); end
        checks++; if (ob1 !== 1'b0) begin errors++; $display("FAIL and_idle_busy: got %b expected 0", ob1); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5];
        logic [7:0] exp_v [5];
        int run;
        int best;
        ops   = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
        exp_v = '{8'hFC, 8'hCC, 8'h33, 8'h0F, 8'hC0};
        run = 0; best = 0;
        a1 = 16'hAA5A; b1 = 16'h2D11; r1 = 8'hFF;
        for (int t = 0; t < 7; t++) begin
            if (t < 5) begin
                v1 = 1'b1; op1 = ops[t];
            end else begin
                v1 = 1'b0;
            end
            step();
            if (ov1 === 1'b1) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            if (t >= 1 && t <= 5) begin
                checks++;
                if (ov1 !== 1'b1 || um1(res1) !== exp_v[t-1] || oe1 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_op%0d: got valid=%b res=%h err=%b expected valid=1 res=%h err=0",
                             t - 1, ov1, um1(res1), oe1, exp_v[t-1]);
                end
            end else begin
                checks++;
                if (ov1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_t%0d: got %b expected 0", t, ov1); end
            end
        end
        checks++; if (best != 5) begin errors++; $display("FAIL b2b_run: got %0d expected 5", best); end
    endtask

    task automatic test_refresh();
        logic [15:0] s_zero;
        logic [15:0] s_rand;
        op1 = 3'd3; a1 = 16'hAA5A; b1 = 16'h2D11; v1 = 1'b1; r1 = 8'h00;
        step();
        r1 = 8'hA5;
        step();
        v1 = 1'b0;
        s_zero = res1;
        checks++; if (ov1 !== 1'b1 || um1(s_zero) !== 8'hCC) begin errors++; $display("FAIL refresh_r00: got valid=%b res=%h expected valid=1 res=cc", ov1, um1(s_zero)); end
        step();
        s_rand = res1;
        checks++; if (ov1 !== 1'b1 || um1(s_rand) !== 8'hCC) begin errors++; $display("FAIL refresh_rA5: got valid=%b res=%h expected valid=1 res=cc", ov1, um1(s_rand)); end
        checks++; if ((s_zero[7:0] ^ s_rand[7:0]) !== 8'hA5) begin errors++; $display("FAIL refresh_share0: got diff %h expected a5", s_zero[7:0] ^ s_rand[7:0]); end
        step();
    endtask

    task automatic test_flush();
        op1 = 3'd0; a1 = 16'hAA5A; b1 = 16'h2D11; r1 = 8'h3C; v1 = 1'b1;
        step();
        v1 = 1'b0; f1 = 1'b1;
        step();
        f1 = 1'b0;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_killed: got %b expected 0", ov1); end
        checks++; if (ob1 !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", ob1); end
        op1 = 3'd2; v1 = 1'b1;
        step();
        v1 = 1'b0;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_stale: got %b expected 0", ov1); end
        step();
        checks++; if (ov1 !== 1'b1 || um1(res1) !== 8'hFC) begin errors++; $display("FAIL flush_next_op: got valid=%b res=%h expected valid=1 res=fc", ov1, um1(res1)); end
        v1 = 1'b1; f1 = 1'b1;
        step();
        v1 = 1'b0; f1 = 1'b0;
        checks++; if (ob1 !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_busy: got %b expected 0", ob1); end
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %b expected 0", ov1); end
        op1 = 3'd6; v1 = 1'b1;
        step();
        op1 = 3'd7;
        step();
        v1 = 1'b0;
        checks++; if (ov1 !== 1'b1 || oe1 !== 1'b1 || res1 !== 16'h0000) begin errors++; $display("FAIL reserved6: got valid=%b err=%b res=%h expected 1 1 0000", ov1, oe1, res1); end
        step();
        checks++; if (ov1 !== 1'b1 || oe1 !== 1'b1 || res1 !== 16'h0000) begin errors++; $display("FAIL reserved7: got valid=%b err=%b res=%h expected 1 1 0000", ov1, oe1, res1); end
        step();
        checks++; if (ov1 !== 1'b0 || oe1 !== 1'b0) begin errors++; $display("FAIL reserved_end: got valid=%b err=%b expected 0 0", ov1, oe1); end
    endtask

    task automatic test_reset_mid();
        op1 = 3'd0; a1 = 16'hAA5A; b1 = 16'h2D11; r1 = 8'h77; v1 = 1'b1;
        step();
        op1 = 3'd3;
        step();
        v1 = 1'b0;
        checks++; if (ov1 !== 1'b1 || ob1 !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got valid=%b busy=%b expected 1 1", ov1, ob1); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (ov1 !== 1'b0 || ob1 !== 1'b0 || res1 !== 16'h0000) begin errors++; $display("FAIL rstmid_clear: got valid=%b busy=%b res=%h expected 0 0 0000", ov1, ob1, res1); end
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rstmid_stale1: got %b expected 0", ov1); end
        step();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rstmid_stale2: got %b expected 0", ov1); end
    endtask

    task automatic test_d2_random();
        logic [8:0]  exp_q [$];
        logic [8:0]  exp;
        logic [31:0] tmp;
        logic        prev_v;
        logic        cur_v;
        prev_v = 1'b0;
        for (int t = 0; t < 1002; t++) begin
            if (t < 1000) begin
                v2  = ($urandom_range(0, 9) < 32'd8);
                tmp = $urandom_range(0, 7);  op2 = tmp[2:0];
                tmp = $urandom();            a2  = tmp[23:0];
                tmp = $urandom();            b2  = tmp[23:0];
                tmp = $urandom();            r2  = tmp[23:0];
            end else begin
                v2 = 1'b0;
            end
            if (v2) begin
                exp_q.push_back({(op2 > 3'd5), ref_op(op2, um2(a2), um2(b2))});
            end
            cur_v = v2;
            step();
            checks++;
            if (ov2 !== prev_v) begin errors++; $display("FAIL d2_valid_t%0d: got %b expected %b", t, ov2, prev_v); end
            if (ov2 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d2_unexpected_t%0d: got valid=1 expected no pending op", t);
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (oe2 !== exp[8]) begin errors++; $display("FAIL d2_err_t%0d: got %b expected %b", t, oe2, exp[8]); end
                    checks++;
                    if (exp[8] && res2 !== 24'h000000) begin
                        errors++; $display("FAIL d2_rsv_t%0d: got %h expected 000000", t, res2);
                    end else if (!exp[8] && um2(res2) !== exp[7:0]) begin
                        errors++; $display("FAIL d2_res_t%0d: got %h expected %h", t, um2(res2), exp[7:0]);
                    end
                end
            end
            prev_v = cur_v;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL d2_leftover: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_refresh();
        test_flush();
        test_reset_mid();
        test_d2_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
